// File: rtl/io_rle_decompressor_pkg.sv
// Shared definitions for the RLE decompressor: word format, widths,
// default stream base addresses and the controller state encoding.
package io_pkg;

    localparam int WORD_W      = 16;   // packed output word width
    localparam int RUN_W       = 15;   // run length field width
    localparam int FILL_W      = 5;    // holds 0..16 bits buffered
    localparam int FMT_BIT_POS = 15;   // run bit value position in a compressed word
    localparam int FMT_LEN_MSB = 14;   // run length occupies [FMT_LEN_MSB:0]

    localparam int DEF_ADDR_W   = 12;
    localparam int DEF_CNN_BASE = 0;
    localparam int DEF_IMG_BASE = 2048;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_EXPAND,
        S_ACK,
        S_GAP,
        S_FLUSH,
        S_START
    } state_e;

endpackage

// File: rtl/io_rle_decompressor_if.sv
// Host command / compressed data inputs and memory write outputs of the
// decompressor. master = host side, slave = decompressor side.
interface io_rle_if #(
    parameter int ADDR_W = io_pkg::DEF_ADDR_W
);
    logic                      interrupt;
    logic                      load;
    logic                      cnn;
    logic [io_pkg::WORD_W-1:0] data;
    logic                      done;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [io_pkg::WORD_W-1:0] mem_wdata;
    logic                      process_start;
    logic                      busy;
    logic                      overflow;

    modport master (
        output interrupt, load, cnn, data,
        input  done, mem_we, mem_addr, mem_wdata, process_start, busy, overflow
    );

    modport slave (
        input  interrupt, load, cnn, data,
        output done, mem_we, mem_addr, mem_wdata, process_start, busy, overflow
    );
endinterface

// File: rtl/io_rle_decompressor_rle_bit_packer.sv
// MSB-first bit packer: appends n copies of one bit below the bits already
// held. word_o shows the word as it will be after this cycle's append, so a
// completed word can be written in the same cycle it fills.
module rle_bit_packer
    import io_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_i,
    input  logic [FILL_W-1:0] n_i,
    input  logic              append_i,
    input  logic              flush_i,
    output logic [WORD_W-1:0] word_o,
    output logic              full_o,
    output logic [FILL_W-1:0] fill_o
);

    logic [WORD_W-1:0] shift_q, shift_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [WORD_W-1:0] run_mask;
    logic [FILL_W-1:0] fill_sum;

    // Build the n-bit mask just below the filled MSBs and the next packer state.
    // Unfilled LSBs are always zero, so OR-ing in ones is enough.
    always_comb begin
        run_mask = ({WORD_W{1'b1}} << (FILL_W'(WORD_W) - n_i)) >> fill_q;
        fill_sum = fill_q + n_i;
        word_o   = shift_q;
        if (append_i && bit_i) begin
            word_o = shift_q | run_mask;
        end
        full_o  = append_i && (fill_sum == FILL_W'(WORD_W));
        shift_d = shift_q;
        fill_d  = fill_q;
        if (flush_i || full_o) begin
            shift_d = '0;
            fill_d  = '0;
        end else if (append_i) begin
            shift_d = word_o;
            fill_d  = fill_sum;
        end
    end

    // Shift register and fill counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            fill_q  <= '0;
        end else begin
            shift_q <= shift_d;
            fill_q  <= fill_d;
        end
    end

    assign fill_o = fill_q;

endmodule

// File: rtl/io_rle_decompressor.sv
// RLE decompressor: captures 16-bit compressed words from the host, expands
// runs into packed words via rle_bit_packer and writes them to memory at a
// per-stream address. A host interrupt preempts everything and first flushes
// any partial word.
module io_rle_decompressor
    import io_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int CNN_BASE = DEF_CNN_BASE,
    parameter int IMG_BASE = DEF_IMG_BASE
) (
    input  logic      clk,
    input  logic      rst,
    io_rle_if.slave   h
);

    localparam logic [ADDR_W-1:0] CNN_ADDR = ADDR_W'(CNN_BASE);
    localparam logic [ADDR_W-1:0] IMG_ADDR = ADDR_W'(IMG_BASE);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ovf_q, ovf_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic              bit_q, bit_d;
    logic              cmd_load_q, cmd_load_d;
    logic              cnn_q, cnn_d;

    logic              pk_append, pk_flush, pk_full;
    logic [WORD_W-1:0] pk_word;
    logic [FILL_W-1:0] pk_fill, space, step_n;
    logic [ADDR_W-1:0] addr_inc;
    logic              addr_wrap;
    logic              we, done, pstart;

    function automatic logic [ADDR_W-1:0] base_addr(input logic sel_cnn);
        return sel_cnn ? CNN_ADDR : IMG_ADDR;
    endfunction

    rle_bit_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .bit_i    (bit_q),
        .n_i      (step_n),
        .append_i (pk_append),
        .flush_i  (pk_flush),
        .word_o   (pk_word),
        .full_o   (pk_full),
        .fill_o   (pk_fill)
    );

    assign space     = FILL_W'(WORD_W) - pk_fill;
    assign step_n    = (run_q < RUN_W'(space)) ? run_q[FILL_W-1:0] : space;
    assign addr_inc  = addr_q + ADDR_W'(1);
    assign addr_wrap = &addr_q;

    // Next-state and output decode; a host interrupt overrides the current state.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        ovf_d      = ovf_q;
        run_d      = run_q;
        bit_d      = bit_q;
        cmd_load_d = cmd_load_q;
        cnn_d      = cnn_q;
        pk_append  = 1'b0;
        pk_flush   = 1'b0;
        we         = 1'b0;
        done       = 1'b0;
        pstart     = 1'b0;
        if (h.interrupt) begin
            // Remember the command so FLUSH can complete it; drop any pending run.
            cmd_load_d = h.load;
            cnn_d      = h.cnn;
            run_d      = '0;
            if (pk_fill != '0) begin
                state_d = S_FLUSH;
            end else if (h.load) begin
                addr_d  = base_addr(h.cnn);
                state_d = S_CAPTURE;
            end else begin
                state_d = S_START;
            end
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_CAPTURE: begin
                    run_d   = h.data[FMT_LEN_MSB:0];
                    bit_d   = h.data[FMT_BIT_POS];
                    state_d = (h.data[FMT_LEN_MSB:0] == '0) ? S_ACK : S_EXPAND;
                end
                S_EXPAND: begin
                    pk_append = 1'b1;
                    run_d     = run_q - RUN_W'(step_n);
                    if (pk_full) begin
                        we     = 1'b1;
                        addr_d = addr_inc;
                        ovf_d  = ovf_q | addr_wrap;
                    end
                    if (run_d == '0) begin
                        state_d = S_ACK;
                    end
                end
                S_ACK: begin
                    done    = 1'b1;
                    state_d = S_GAP;
                end
                S_GAP: state_d = S_CAPTURE;
                S_FLUSH: begin
                    pk_flush = 1'b1;
                    we       = 1'b1;
                    ovf_d    = ovf_q | addr_wrap;
                    if (cmd_load_q) begin
                        addr_d  = base_addr(cnn_q);
                        state_d = S_CAPTURE;
                    end else begin
                        addr_d  = addr_inc;
                        state_d = S_START;
                    end
                end
                S_START: begin
                    pstart  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Controller state, address counter and captured run registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            ovf_q      <= 1'b0;
            run_q      <= '0;
            bit_q      <= 1'b0;
            cmd_load_q <= 1'b0;
            cnn_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            ovf_q      <= ovf_d;
            run_q      <= run_d;
            bit_q      <= bit_d;
            cmd_load_q <= cmd_load_d;
            cnn_q      <= cnn_d;
        end
    end

    assign h.done          = done;
    assign h.mem_we        = we;
    assign h.mem_addr      = addr_q;
    assign h.mem_wdata     = we ? pk_word : '0;
    assign h.process_start = pstart;
    assign h.busy          = (state_q != S_IDLE);
    assign h.overflow      = ovf_q;

endmodule

// File: tb/tb_io_rle_decompressor.sv
// Bench for io_rle_decompressor: two instances (12-bit default map and a
// 4-bit map with CNN base 14) share one stimulus; a bit-level reference
// model queues the expected memory writes of each.
module tb_io_rle_decompressor;
    import io_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    io_rle_if #(.ADDR_W(12)) h1 ();
    io_rle_if #(.ADDR_W(4))  h2 ();

    assign h2.interrupt = h1.interrupt;
    assign h2.load      = h1.load;
    assign h2.cnn       = h1.cnn;
    assign h2.data      = h1.data;

    io_rle_decompressor #(.ADDR_W(12), .CNN_BASE(0), .IMG_BASE(2048)) dut1 (
        .clk (clk),
        .rst (rst),
        .h   (h1)
    );

    io_rle_decompressor #(.ADDR_W(4), .CNN_BASE(14), .IMG_BASE(8)) dut2 (
        .clk (clk),
        .rst (rst),
        .h   (h2)
    );

    int n_checks = 0;
    int n_bad    = 0;
    int ps_exp   = 0;
    int ps_seen1 = 0;
    int ps_seen2 = 0;

    // reference model state, index 0 = dut1, 1 = dut2
    int          m_fill [2];
    logic [15:0] m_shift[2];
    int          m_addr [2];
    logic        m_ovf  [2];
    int          m_aw   [2] = '{12, 4};
    int          m_cbase[2] = '{0, 14};
    int          m_ibase[2] = '{2048, 8};
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_fill[d]  = 0;
            m_shift[d] = '0;
            m_addr[d]  = 0;
            m_ovf[d]   = 1'b0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic model_push(input int d);
        logic [31:0] v;
        v = {16'(m_addr[d]), m_shift[d]};
        if (d == 0) q0.push_back(v);
        else        q1.push_back(v);
        m_addr[d] = m_addr[d] + 1;
        if (m_addr[d] == (1 << m_aw[d])) begin
            m_addr[d] = 0;
            m_ovf[d]  = 1'b1;
        end
        m_shift[d] = '0;
        m_fill[d]  = 0;
    endtask

    task automatic model_word(input logic [15:0] w);
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < int'(w[14:0]); i++) begin
                m_shift[d][15 - m_fill[d]] = w[15];
                m_fill[d]++;
                if (m_fill[d] == 16) model_push(d);
            end
        end
    endtask

    task automatic model_cmd(input logic ld, input logic c);
        for (int d = 0; d < 2; d++) begin
            if (m_fill[d] > 0) model_push(d);
            if (ld) m_addr[d] = c ? m_cbase[d] : m_ibase[d];
        end
        if (!ld) ps_exp++;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!h1.done && k < 300);
        check(tag, 32'(h1.done), 32'd1);
        check({tag, "_d2"}, 32'(h2.done), 32'd1);
    endtask

    // present next word (called while done is high)
    task automatic send_word(input logic [15:0] w, input string tag);
        h1.data = w;
        model_word(w);
        wait_done(tag);
    endtask

    task automatic send_cmd(input logic ld, input logic c, input logic [15:0] w, input logic wait_it);
        model_cmd(ld, c);
        h1.interrupt = 1'b1;
        h1.load      = ld;
        h1.cnn       = c;
        h1.data      = w;
        tick();
        h1.interrupt = 1'b0;
        if (ld) begin
            model_word(w);
            if (wait_it) wait_done($sformatf("cmd_done_%h", w));
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_d1"}, {h1.done, h1.mem_we, h1.process_start, h1.busy, h1.overflow,
                             11'(h1.mem_addr), h1.mem_wdata}, 32'd0);
        check({tag, "_d2"}, {h2.done, h2.mem_we, h2.process_start, h2.busy, h2.overflow,
                             11'(h2.mem_addr), h2.mem_wdata}, 32'd0);
    endtask

    // write monitor / scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            if (h1.mem_we) begin
                logic [31:0] e;
                e = (q0.size() > 0) ? q0.pop_front() : 32'hDEAD_BEEF;
                $display("dut1 write addr=%0d data=%h exp=%h", h1.mem_addr, h1.mem_wdata, e);
                check("d1_write", {16'(h1.mem_addr), h1.mem_wdata}, e);
                check("d1_done_with_we", 32'(h1.done), 32'd0);
            end
            if (h2.mem_we) begin
                logic [31:0] e;
                e = (q1.size() > 0) ? q1.pop_front() : 32'hDEAD_BEEF;
                $display("dut2 write addr=%0d data=%h exp=%h", h2.mem_addr, h2.mem_wdata, e);
                check("d2_write", {16'(h2.mem_addr), h2.mem_wdata}, e);
                check("d2_done_with_we", 32'(h2.done), 32'd0);
            end
            if (h1.process_start) ps_seen1++;
            if (h2.process_start) ps_seen2++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        h1.interrupt = 1'b0;
        h1.load      = 1'b0;
        h1.cnn       = 1'b0;
        h1.data      = 16'h0000;
        model_reset();
        repeat (3) tick();
        check_reset_outs("reset");
        rst = 1'b1;
        tick();

        // full word, zero-length run, then wrap on the 4-bit instance
        send_cmd(1'b1, 1'b1, 16'h8010, 1'b1);
        send_word(16'h0000, "zero_run");
        send_word(16'h8010, "full2");
        send_word(16'h8010, "full3");
        send_word(16'h0000, "idle_a");
        check("ovf_d1", 32'(h1.overflow), 32'(m_ovf[0]));
        check("ovf_d2", 32'(h2.overflow), 32'(m_ovf[1]));

        // two half runs make one word; image partial flushed by processing cmd
        send_cmd(1'b1, 1'b1, 16'h0008, 1'b1);
        send_word(16'h8008, "half_ones");
        send_word(16'h0000, "idle_b");
        send_cmd(1'b1, 1'b0, 16'h8003, 1'b1);
        send_word(16'h0000, "idle_c");
        send_cmd(1'b0, 1'b0, 16'h0000, 1'b0);
        repeat (4) tick();
        check("pstart_d1", 32'(ps_seen1), 32'(ps_exp));
        check("pstart_d2", 32'(ps_seen2), 32'(ps_exp));
        check("busy_idle_d1", 32'(h1.busy), 32'd0);
        check("busy_idle_d2", 32'(h2.busy), 32'd0);

        // run 40 after fill 10, then top up to fill 5
        send_cmd(1'b1, 1'b1, 16'h000A, 1'b1);
        send_word(16'h8028, "run40");
        send_word(16'h8003, "fill5");

        // run 100 interrupted on its first expand step
        h1.data = 16'h0064;
        repeat (3) tick();
        send_cmd(1'b1, 1'b0, 16'h8010, 1'b1);
        send_word(16'h0000, "idle_d");
        check("ovf_sticky_d2", 32'(h2.overflow), 32'(m_ovf[1]));
        check("ovf_d1_b", 32'(h1.overflow), 32'(m_ovf[0]));

        // reset in the middle of a long run
        send_cmd(1'b1, 1'b1, 16'h81F4, 1'b0);
        repeat (4) tick();
        rst = 1'b0;
        #1;
        check_reset_outs("reset_mid");
        model_reset();
        tick();
        rst = 1'b1;
        tick();
        send_cmd(1'b1, 1'b1, 16'h8010, 1'b1);
        send_word(16'h0000, "idle_e");
        check("ovf_after_rst_d2", 32'(h2.overflow), 32'(m_ovf[1]));

        repeat (3) tick();
        check("q_empty_d1", 32'(q0.size()), 32'd0);
        check("q_empty_d2", 32'(q1.size()), 32'd0);
        check("pstart_final_d1", 32'(ps_seen1), 32'(ps_exp));

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/io_rle_decompressor.md
Name: io_rle_decompressor

Overview:
- Downstream consumer of the GPU host driver's 16-bit compressed word stream.
- Decodes run-length-encoded bit runs into packed 16-bit words and writes them to accelerator memory.
- Separate base address for each stream: CNN weights (cnn=1) and image (cnn=0).
- Pulses done to request the next compressed word; pulses process_start when the host signals the processing phase (load=0).

Parameters:
- ADDR_W, 12, memory address width in words.
- CNN_BASE, 0, first write address for the CNN stream.
- IMG_BASE, 2048, first write address for the image stream.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- interrupt  input  1  host command strobe; sampled high for one cycle.
- load  input  1  1 = load stream command, 0 = start processing command.
- cnn  input  1  stream select, valid with interrupt; 1 = CNN, 0 = image.
- data  input  16  compressed word: bit15 = run bit value, bits14:0 = run length (0..32767).
- done  output  1  one-cycle pulse: current word consumed; host presents next word.
- mem_we  output  1  memory write strobe.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  16  packed output word; first decoded bit lands at bit15 (MSB-first).
- process_start  output  1  one-cycle pulse on a processing command.
- busy  output  1  high in any state other than IDLE.
- overflow  output  1  sticky; set when mem_addr wraps; cleared only by reset.

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; fill counter=0; shift register=0; run counter=0; address=0.
- States: IDLE, CAPTURE, EXPAND, ACK, GAP, FLUSH, START.
- interrupt=1 in any state (priority over all other activity):
  - If fill>0: go to FLUSH. FLUSH writes the shift register zero-padded at the LSBs to mem_addr, increments the address, clears fill. Takes 1 cycle, then continues the command below.
  - Load command (load=1): latch cnn; address = cnn ? CNN_BASE : IMG_BASE; go to CAPTURE.
  - Processing command (load=0): go to START; process_start=1 for one cycle; then IDLE.
  - A remaining run from an aborted word is discarded.
- CAPTURE (1 cycle): register data; run_rem = data[14:0], bit = data[15].
  - If run_rem=0, go directly to ACK.
  - Otherwise go to EXPAND.
- EXPAND (one cycle per step):
  - n = min(run_rem, 16 - fill).
  - Append n copies of bit below the already-filled MSBs; fill += n; run_rem -= n.
  - If fill reaches 16: mem_we=1 that cycle with the full word; address += 1; fill=0.
  - When run_rem reaches 0: go to ACK.
- Example: fill=10 with run 40 → writes at cycles 1, 2 and 3 (6, 16, 16 bits); 2 bits remain buffered.
- ACK: done=1 for exactly one cycle. The host updates data on the following falling edge.
- GAP: 1 idle cycle, then CAPTURE. GAP guarantees data is stable before it is sampled.
- Address wrap: incrementing from 2^ADDR_W-1 yields 0 and sets overflow.
- The host has no explicit end-of-stream marker. The trailing partial word is written only by the FLUSH triggered by the next interrupt.
- mem_we and done are never high in the same cycle.
- Arithmetic widths: fill is 5 bits (0..16); run_rem is 15 bits; n is 5 bits.

Decomposition:
- Shared package io_pkg: state enum, WORD_W=16, RUN_W=15, format bit positions, default base addresses.
- One sub-module, rle_bit_packer: holds the shift register and fill counter.
  - Inputs: bit, n, append, flush.
  - Outputs: word, full.
  - The FSM and address counter stay in io_rle_decompressor.

Test Plan:
- Reset mid-EXPAND (rst=0 during run 500) → all outputs 0 immediately; next interrupt/load=1/cnn=1 → writes restart at address 0.
- interrupt, load=1, cnn=1, data=0x8010 (sixteen 1s) → one write of 0xFFFF at address 0, then a done pulse; next data=0x0000 → done with no write.
- data=0x0008 then 0x8008 → single write of 0x00FF at CNN_BASE. Then interrupt, load=1, cnn=0 with data=0x8003 → 3 cycles later interrupt, load=0 → FLUSH writes 0xE000 at IMG_BASE, then process_start pulses once.
- Run 40 of 1s after fill=10 of 0s → writes 0x003F, 0xFFFF, 0xFFFF on consecutive cycles; fill=2 remains; done follows the last write.
- ADDR_W=4, CNN_BASE=14, three full words → writes at addresses 14, 15, 0; overflow=1 and stays 1.
- interrupt (load=1, cnn=0) while run_rem=100 with fill=5 → FLUSH writes the padded partial word; remaining run is dropped; next write goes to IMG_BASE.
